// File: rtl/pe_row_conv_pkg.sv
// Shared types and helpers for the row-convolution PE.
//   state_t     : controller states (IDLE -> MAC -> DONE -> IDLE)
//   acc_width() : accumulator width so FILT_LEN full-width products never overflow
//   cnt_width() : counter width for a 0..n-1 counter (at least 1 bit)
//   sat_psum()  : clamp a wide signed sum into a psum_w-bit signed range
package pe_row_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Widest sum the saturation helper accepts; callers sign-extend into it.
  localparam int SAT_W = 64;

  function automatic int acc_width(input int data_w, input int filt_len);
    return 2 * data_w + $clog2(filt_len) + 2;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_psum(
    input logic signed [SAT_W-1:0] sum,
    input int                      psum_w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (psum_w - 1)) - 64'sd1;
    lo = ~hi;  // == -hi - 1, the most negative psum value
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/pe_row_conv_mac.sv
// Single time-multiplexed MAC for the row PE.
//   clk, rst    : clock, synchronous active-high reset
//   i_acc_clr   : clear accumulator (wins over i_acc_en)
//   i_acc_en    : add the current product into the accumulator
//   i_f, i_d    : signed filter / ifmap operands
//   o_prod      : (i_f*i_d) >>> FRAC_W, sign-extended to ACC_W (combinational)
//   o_acc       : registered running sum of earlier products
module pe_row_conv_mac
  import pe_row_conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 0,
  parameter int ACC_W  = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_acc_clr,
  input  logic                     i_acc_en,
  input  logic        [DATA_W-1:0] i_f,
  input  logic        [DATA_W-1:0] i_d,
  output logic signed [ACC_W-1:0]  o_prod,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [2*DATA_W-1:0] w_mult;
  logic signed [2*DATA_W-1:0] w_shift;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_mult  = $signed(i_f) * $signed(i_d);
  // Scaling is applied per product, before accumulation.
  assign w_shift = w_mult >>> FRAC_W;
  assign o_prod  = ACC_W'(w_shift);
  assign o_acc   = r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_acc_clr) begin
      r_acc <= '0;
    end else if (i_acc_en) begin
      r_acc <= r_acc + o_prod;
    end
  end

endmodule

// File: rtl/pe_row_conv.sv
// Row PE: 1-D convolution of one filter row with one ifmap row plus an
// optional incoming psum row, one MAC per cycle. Input rows are latched
// at start and forwarded for systolic reuse.
// Ports (element i of a flattened row lives at [i*W +: W]):
//   clk, rst     : clock, synchronous active-high reset
//   en           : start request, only looked at in IDLE
//   accum_en     : 1 = add PSUM_IN row, 0 = treat it as zeros
//   FILTER_IN    : filter row, FILT_LEN elements
//   DATA_IN      : ifmap row, IFMAP_LEN elements
//   PSUM_IN      : incoming psum row, OUT_LEN elements
//   FILTER_OUT   : latched filter row
//   DATA_OUT     : latched ifmap row
//   PSUM_OUT     : saturated result row
//   BUSY         : high in MAC and DONE
//   DONE         : one-cycle pulse when PSUM_OUT is complete
//   o_dbg_state  : current controller state (state_t encoding)
// Handshake: a start is accepted on the edge where en=1 and the PE is idle
// (BUSY=0); en at any other time is dropped, nothing is queued. DONE
// pulses for exactly one cycle per accepted start; the next start can be
// accepted in the cycle after DONE. Inputs are free to change after the
// accepting edge.
module pe_row_conv
  import pe_row_conv_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PSUM_W    = 16,
  parameter int FILT_LEN  = 3,
  parameter int IFMAP_LEN = 7,
  parameter int STRIDE    = 1,
  parameter int FRAC_W    = 0
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  en,
  input  logic                                                  accum_en,
  input  logic [FILT_LEN*DATA_W-1:0]                            FILTER_IN,
  input  logic [IFMAP_LEN*DATA_W-1:0]                           DATA_IN,
  input  logic [((IFMAP_LEN-FILT_LEN)/STRIDE+1)*PSUM_W-1:0]     PSUM_IN,
  output logic [FILT_LEN*DATA_W-1:0]                            FILTER_OUT,
  output logic [IFMAP_LEN*DATA_W-1:0]                           DATA_OUT,
  output logic [((IFMAP_LEN-FILT_LEN)/STRIDE+1)*PSUM_W-1:0]     PSUM_OUT,
  output logic                                                  BUSY,
  output logic                                                  DONE,
  output logic [1:0]                                            o_dbg_state
);

  localparam int OUT_LEN = (IFMAP_LEN - FILT_LEN) / STRIDE + 1;
  localparam int ACC_W   = acc_width(DATA_W, FILT_LEN);
  localparam int SUM_W   = ACC_W + 2;
  localparam int K_W     = cnt_width(FILT_LEN);
  localparam int O_W     = cnt_width(OUT_LEN);
  localparam logic [K_W-1:0] K_LAST = K_W'(FILT_LEN - 1);
  localparam logic [O_W-1:0] O_LAST = O_W'(OUT_LEN - 1);

  state_t                       r_state;
  logic [FILT_LEN*DATA_W-1:0]   r_filt;
  logic [IFMAP_LEN*DATA_W-1:0]  r_data;
  logic [OUT_LEN*PSUM_W-1:0]    r_psum;
  logic [OUT_LEN*PSUM_W-1:0]    r_psum_out;
  logic [K_W-1:0]               r_k;
  logic [O_W-1:0]               r_o;
  logic                         r_busy;
  logic                         r_done;

  int                           w_f_idx;
  int                           w_d_idx;
  int                           w_o_idx;
  logic [DATA_W-1:0]            w_f;
  logic [DATA_W-1:0]            w_d;
  logic signed [PSUM_W-1:0]     w_psum_elem;
  logic signed [ACC_W-1:0]      w_prod;
  logic signed [ACC_W-1:0]      w_acc;
  logic signed [SUM_W-1:0]      w_sum;
  logic [PSUM_W-1:0]            w_sat;
  logic                         w_k_last;
  logic                         w_acc_clr;
  logic                         w_acc_en;

  // Operand select: f[k] and d[o*STRIDE+k].
  always_comb begin
    w_f_idx     = int'(r_k);
    w_o_idx     = int'(r_o);
    w_d_idx     = w_o_idx * STRIDE + w_f_idx;
    w_f         = r_filt[w_f_idx*DATA_W +: DATA_W];
    w_d         = r_data[w_d_idx*DATA_W +: DATA_W];
    w_psum_elem = r_psum[w_o_idx*PSUM_W +: PSUM_W];
  end

  assign w_k_last = (r_k == K_LAST);
  // Accumulator is cleared while idle (ready for a capture) and on the
  // edge that retires an output element.
  assign w_acc_clr = (r_state == ST_IDLE) || ((r_state == ST_MAC) && w_k_last);
  assign w_acc_en  = (r_state == ST_MAC);

  pe_row_conv_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .i_acc_clr (w_acc_clr),
    .i_acc_en  (w_acc_en),
    .i_f       (w_f),
    .i_d       (w_d),
    .o_prod    (w_prod),
    .o_acc     (w_acc)
  );

  // The last product of an element is folded in directly, so the element
  // is written on the same edge it is multiplied.
  always_comb begin
    w_sum = SUM_W'(w_psum_elem) + SUM_W'(w_acc) + SUM_W'(w_prod);
    w_sat = PSUM_W'(sat_psum(SAT_W'(w_sum), PSUM_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_filt     <= '0;
      r_data     <= '0;
      r_psum     <= '0;
      r_psum_out <= '0;
      r_k        <= '0;
      r_o        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (en) begin
            r_filt  <= FILTER_IN;
            r_data  <= DATA_IN;
            r_psum  <= accum_en ? PSUM_IN : '0;
            r_k     <= '0;
            r_o     <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (w_k_last) begin
            r_psum_out[w_o_idx*PSUM_W +: PSUM_W] <= w_sat;
            r_k <= '0;
            if (r_o == O_LAST) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_o <= r_o + O_W'(1);
            end
          end else begin
            r_k <= r_k + K_W'(1);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign FILTER_OUT  = r_filt;
  assign DATA_OUT    = r_data;
  assign PSUM_OUT    = r_psum_out;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pe_row_conv.sv
module tb_pe_row_conv;

  localparam int DW    = 16;
  localparam int PW    = 16;
  localparam int FL    = 3;
  localparam int IL    = 7;
  localparam int OL    = 5;
  localparam int OL2   = 3;
  localparam int FRAC  = 0;
  localparam int LIMIT = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               en;
  logic               en_s2;
  logic               accum_en;
  logic [FL*DW-1:0]   filt_in;
  logic [IL*DW-1:0]   data_in;
  logic [OL*PW-1:0]   psum_in;
  logic [OL2*PW-1:0]  psum_in_s2;

  logic [FL*DW-1:0]   filter_out;
  logic [IL*DW-1:0]   data_out;
  logic [OL*PW-1:0]   psum_out;
  logic               busy;
  logic               done;
  logic [1:0]         dbg_state;

  logic [FL*DW-1:0]   filter_out_s2;
  logic [IL*DW-1:0]   data_out_s2;
  logic [OL2*PW-1:0]  psum_out_s2;
  logic               busy_s2;
  logic               done_s2;
  logic [1:0]         dbg_state_s2;

  pe_row_conv u_dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .accum_en    (accum_en),
    .FILTER_IN   (filt_in),
    .DATA_IN     (data_in),
    .PSUM_IN     (psum_in),
    .FILTER_OUT  (filter_out),
    .DATA_OUT    (data_out),
    .PSUM_OUT    (psum_out),
    .BUSY        (busy),
    .DONE        (done),
    .o_dbg_state (dbg_state)
  );

  pe_row_conv #(.STRIDE(2)) u_dut_s2 (
    .clk         (clk),
    .rst         (rst),
    .en          (en_s2),
    .accum_en    (accum_en),
    .FILTER_IN   (filt_in),
    .DATA_IN     (data_in),
    .PSUM_IN     (psum_in_s2),
    .FILTER_OUT  (filter_out_s2),
    .DATA_OUT    (data_out_s2),
    .PSUM_OUT    (psum_out_s2),
    .BUSY        (busy_s2),
    .DONE        (done_s2),
    .o_dbg_state (dbg_state_s2)
  );

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // Reference convolution: pushes one expected element per output.
  function automatic void push_expected(input logic [FL*DW-1:0] f, input logic [IL*DW-1:0] d,
                                        input logic [OL*PW-1:0] p, input bit acc, input int stride);
    int out_len;
    longint s, fv, dv, hi, lo;
    logic signed [DW-1:0] fe;
    logic signed [DW-1:0] de;
    logic signed [PW-1:0] pe;
    hi = (64'sd1 <<< (PW - 1)) - 1;
    lo = -hi - 1;
    out_len = (IL - FL) / stride + 1;
    for (int o = 0; o < out_len; o++) begin
      pe = p[o*PW +: PW];
      s = 0;
      if (acc) s = pe;
      for (int k = 0; k < FL; k++) begin
        fe = f[k*DW +: DW];
        de = d[(o*stride+k)*DW +: DW];
        fv = fe;
        dv = de;
        s = s + ((fv * dv) >>> FRAC);
      end
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
      exp_q.push_back(s[PW-1:0]);
    end
  endfunction

  function automatic logic [IL*DW-1:0] ramp_data();
    logic [IL*DW-1:0] d;
    for (int i = 0; i < IL; i++) d[i*DW +: DW] = DW'(i + 1);
    return d;
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < FL; i++) filt_in[i*DW +: DW] = DW'($urandom_range(0, 65535));
    for (int i = 0; i < IL; i++) data_in[i*DW +: DW] = DW'($urandom_range(0, 65535));
    for (int i = 0; i < OL; i++) psum_in[i*PW +: PW] = PW'($urandom_range(0, 65535));
    accum_en = 1'($urandom_range(0, 1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    en_s2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Full run on the default-build DUT, scoreboard compare at DONE.
  task automatic run_conv(input string name, input logic [FL*DW-1:0] f, input logic [IL*DW-1:0] d,
                          input bit acc, input logic [OL*PW-1:0] p);
    int lat;
    logic [PW-1:0] exp_v;
    filt_in = f;
    data_in = d;
    psum_in = p;
    accum_en = acc;
    en = 1'b1;
    push_expected(f, d, p, acc, 1);
    @(posedge clk);
    #1;
    en = 1'b0;
    scramble_inputs();
    checks++;
    if (busy !== 1'b1 || dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL %s start: busy=%b state=%0d, want busy=1 state=1", name, busy, dbg_state);
    end
    lat = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != OL * FL) begin
      errors++;
      $display("FAIL %s latency: done after %0d edges, want %0d", name, lat, OL * FL);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b want 1", name, busy);
    end
    for (int o = 0; o < OL; o++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (psum_out[o*PW +: PW] !== exp_v) begin
        errors++;
        $display("FAIL %s psum[%0d]: got %h want %h", name, o, psum_out[o*PW +: PW], exp_v);
      end
    end
    checks++;
    if (filter_out !== f) begin
      errors++;
      $display("FAIL %s filter_out: got %h want %h", name, filter_out, f);
    end
    checks++;
    if (data_out !== d) begin
      errors++;
      $display("FAIL %s data_out: got %h want %h", name, data_out, d);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b, want 0 0", name, done, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (psum_out !== '0 || filter_out !== '0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset rows: psum=%h filt=%h data=%h, want 0", psum_out, filter_out, data_out);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset ctrl: busy=%b done=%b state=%0d, want 0 0 0", busy, done, dbg_state);
    end
  endtask

  task automatic test_basic();
    logic [OL*PW-1:0] want;
    want = {16'd38, 16'd32, 16'd26, 16'd20, 16'd14};
    run_conv("basic", {16'd3, 16'd2, 16'd1}, ramp_data(), 1'b0, '0);
    checks++;
    if (psum_out !== want) begin
      errors++;
      $display("FAIL basic const: got %h want %h", psum_out, want);
    end
  endtask

  task automatic test_accum();
    logic [OL*PW-1:0] want;
    want = {16'd538, 16'd432, 16'd326, 16'd220, 16'd114};
    run_conv("accum", {16'd3, 16'd2, 16'd1}, ramp_data(), 1'b1,
             {16'd500, 16'd400, 16'd300, 16'd200, 16'd100});
    checks++;
    if (psum_out !== want) begin
      errors++;
      $display("FAIL accum const: got %h want %h", psum_out, want);
    end
  endtask

  task automatic test_saturation();
    run_conv("sat_pos", {3{16'h7FFF}}, {7{16'h7FFF}}, 1'b0, '0);
    checks++;
    if (psum_out !== {5{16'h7FFF}}) begin
      errors++;
      $display("FAIL sat_pos const: got %h want all 7fff", psum_out);
    end
    run_conv("sat_neg", {3{16'h8000}}, {7{16'h7FFF}}, 1'b1, {5{16'h8000}});
    checks++;
    if (psum_out !== {5{16'h8000}}) begin
      errors++;
      $display("FAIL sat_neg const: got %h want all 8000", psum_out);
    end
    run_conv("neg_one", {16'h0000, 16'h0000, 16'hFFFF}, ramp_data(), 1'b0, '0);
    checks++;
    if (psum_out !== {16'hFFFB, 16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF}) begin
      errors++;
      $display("FAIL neg_one const: got %h want fffb..ffff", psum_out);
    end
  endtask

  task automatic test_random();
    logic [FL*DW-1:0] f;
    logic [IL*DW-1:0] d;
    logic [OL*PW-1:0] p;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < FL; i++) f[i*DW +: DW] = DW'($urandom_range(0, 65535));
      for (int i = 0; i < IL; i++) d[i*DW +: DW] = DW'($urandom_range(0, 65535));
      for (int i = 0; i < OL; i++) p[i*PW +: PW] = PW'($urandom_range(0, 65535));
      run_conv("random", f, d, 1'($urandom_range(0, 1)), p);
    end
  endtask

  task automatic test_stride2();
    int lat;
    logic [PW-1:0] exp_v;
    filt_in = {16'd3, 16'd2, 16'd1};
    data_in = ramp_data();
    psum_in_s2 = '0;
    accum_en = 1'b0;
    push_expected(filt_in, data_in, '0, 1'b0, 2);
    en_s2 = 1'b1;
    @(posedge clk);
    #1;
    en_s2 = 1'b0;
    lat = 0;
    while (done_s2 !== 1'b1 && lat < LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != OL2 * FL) begin
      errors++;
      $display("FAIL stride2 latency: done after %0d edges, want %0d", lat, OL2 * FL);
    end
    for (int o = 0; o < OL2; o++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (psum_out_s2[o*PW +: PW] !== exp_v) begin
        errors++;
        $display("FAIL stride2 psum[%0d]: got %h want %h", o, psum_out_s2[o*PW +: PW], exp_v);
      end
    end
    checks++;
    if (psum_out_s2 !== {16'd38, 16'd26, 16'd14}) begin
      errors++;
      $display("FAIL stride2 const: got %h want 0026001a000e", psum_out_s2);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy_s2 !== 1'b0 || done_s2 !== 1'b0) begin
      errors++;
      $display("FAIL stride2 idle: busy=%b done=%b, want 0 0", busy_s2, done_s2);
    end
  endtask

  // en held high: one DONE per accepted start, second start two edges after DONE.
  task automatic test_en_held();
    int n_done;
    int first;
    int second;
    logic [PW-1:0] exp_v;
    filt_in = {16'd3, 16'd2, 16'd1};
    data_in = ramp_data();
    accum_en = 1'b0;
    psum_in = '0;
    push_expected(filt_in, data_in, psum_in, 1'b0, 1);
    push_expected(filt_in, data_in, psum_in, 1'b0, 1);
    en = 1'b1;
    n_done = 0;
    first = -1;
    second = -1;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk);
      #1;
      if (e == 17) en = 1'b0;
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) first = e;
        else if (second < 0) second = e;
        for (int o = 0; o < OL; o++) begin
          exp_v = exp_q.pop_front();
          checks++;
          if (psum_out[o*PW +: PW] !== exp_v) begin
            errors++;
            $display("FAIL en_held psum[%0d]: got %h want %h", o, psum_out[o*PW +: PW], exp_v);
          end
        end
      end
    end
    checks++;
    if (n_done != 2 || first != 15 || second != 32) begin
      errors++;
      $display("FAIL en_held count: dones=%0d at %0d,%0d want 2 at 15,32", n_done, first, second);
    end
    exp_q.delete();
  endtask

  task automatic test_en_at_done();
    int lat;
    int busy_seen;
    logic [PW-1:0] exp_v;
    filt_in = {16'd1, 16'd1, 16'd1};
    data_in = ramp_data();
    accum_en = 1'b0;
    push_expected(filt_in, data_in, '0, 1'b0, 1);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int o = 0; o < OL; o++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (psum_out[o*PW +: PW] !== exp_v) begin
        errors++;
        $display("FAIL en_at_done psum[%0d]: got %h want %h", o, psum_out[o*PW +: PW], exp_v);
      end
    end
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    busy_seen = 0;
    for (int e = 0; e < 20; e++) begin
      if (busy !== 1'b0 || done !== 1'b0) busy_seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL en_at_done ignored: busy/done seen %0d cycles, want 0", busy_seen);
    end
  endtask

  task automatic test_reset_mid_mac();
    int done_seen;
    filt_in = {16'd3, 16'd2, 16'd1};
    data_in = ramp_data();
    accum_en = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL mid_rst ctrl: busy=%b done=%b state=%0d, want 0 0 0", busy, done, dbg_state);
    end
    checks++;
    if (psum_out !== '0) begin
      errors++;
      $display("FAIL mid_rst psum: got %h want 0", psum_out);
    end
    done_seen = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL mid_rst no_done: done seen %0d times, want 0", done_seen);
    end
    run_conv("after_rst", {16'd3, 16'd2, 16'd1}, ramp_data(), 1'b1,
             {16'd500, 16'd400, 16'd300, 16'd200, 16'd100});
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1;
    en = 1'b0;
    en_s2 = 1'b0;
    accum_en = 1'b0;
    filt_in = '0;
    data_in = '0;
    psum_in = '0;
    psum_in_s2 = '0;
    test_reset();
    test_basic();
    test_accum();
    test_saturation();
    test_random();
    test_stride2();
    test_en_held();
    test_en_at_done();
    test_reset_mid_mac();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: %0d entries, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
